adc_snap_ctrl: RTL and testbench

//  Arm/trigger/capture sequencer feeding the ADC-input readout software registers. Software arms via a
//  ppc2simulink control word. On trigger the block latches the timestamp and NUM_WORDS ADC words into a shadow

---
 rtl/adc_snap_pkg.sv | 36 +++
 rtl/snap_edge_det.sv | 24 ++
 rtl/adc_snap_ctrl.sv | 138 +++++++++++++
 tb/tb_adc_snap_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/adc_snap_pkg.sv
// adc_snap_pkg: shared state codes, control/status bit positions and status packing for adc_snap_ctrl
package adc_snap_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ARMED   = 2'd1;
    localparam state_t ST_CAPTURE = 2'd2;
    localparam state_t ST_DONE    = 2'd3;

    localparam int CTRL_ARM   = 0;
    localparam int CTRL_CLR   = 1;
    localparam int CTRL_FORCE = 2;
    localparam int CTRL_N     = 3;

    localparam int STAT_ARMED     = 0;
    localparam int STAT_CAPTURING = 1;
    localparam int STAT_DONE      = 2;
    localparam int STAT_MISSED    = 3;
    localparam int STAT_CNT_LSB   = 8;

    localparam int CNT_W = 8;

    function automatic logic [31:0] pack_status(input state_t st, input logic missed,
                                                input logic [CNT_W-1:0] cnt);
        logic [31:0] s;
        s = '0;
        s[STAT_ARMED]     = st == ST_ARMED;
        s[STAT_CAPTURING] = st == ST_CAPTURE;
        s[STAT_DONE]      = st == ST_DONE;
        s[STAT_MISSED]    = missed;
        s[STAT_CNT_LSB +: CNT_W] = cnt;
        return s;
    endfunction

endpackage

// File: rtl/snap_edge_det.sv
// snap_edge_det: registered N-bit rising-edge detector, one-cycle pulse per low-to-high transition
module snap_edge_det #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] din,
    output logic [N-1:0] rise
);

    logic [N-1:0] prev;

    // sample inputs once and emit a registered pulse on each rising bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
            rise <= '0;
        end else begin
            prev <= din;
            rise <= din & ~prev;
        end
    end

endmodule

// File: rtl/adc_snap_ctrl.sv
// adc_snap_ctrl: arm/trigger/capture sequencer that publishes a coherent timestamp+ADC snapshot in one cycle
module adc_snap_ctrl
    import adc_snap_pkg::*;
#(
    parameter int NUM_WORDS = 4,
    parameter int DATA_W    = 32,
    parameter int TS_W      = 32
) (
    input  logic                        user_clk,
    input  logic                        user_rst_n,
    input  logic [31:0]                 ctrl_in,
    input  logic                        trig_in,
    input  logic [TS_W-1:0]             ts_in,
    input  logic [DATA_W-1:0]           data_in,
    input  logic                        data_vld,
    output logic [TS_W-1:0]             snap_ts,
    output logic [NUM_WORDS*DATA_W-1:0] snap_data,
    output logic [31:0]                 status_out
);

    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_WORDS - 1);

    logic [CTRL_N-1:0]           rise;
    state_t                      state, state_nx;
    logic [IDX_W-1:0]            idx, idx_nx;
    logic                        missed, missed_nx;
    logic [CNT_W-1:0]            cap_cnt, cap_cnt_nx;
    logic                        accept, wr, complete;
    logic [TS_W-1:0]             shadow_ts;
    logic [NUM_WORDS*DATA_W-1:0] shadow, shadow_nx;
    logic                        unused_ctrl;

    assign unused_ctrl = ^ctrl_in[31:CTRL_N];

    snap_edge_det #(.N(CTRL_N)) u_edge (
        .clk   (user_clk),
        .rst_n (user_rst_n),
        .din   (ctrl_in[CTRL_N-1:0]),
        .rise  (rise)
    );

    // next-state decode; clear beats arm, arm beats trigger
    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        missed_nx = missed;
        accept    = 1'b0;
        wr        = 1'b0;
        complete  = 1'b0;
        if (rise[CTRL_CLR]) begin
            state_nx  = ST_IDLE;
            idx_nx    = '0;
            missed_nx = 1'b0;
        end else begin
            case (state)
                ST_IDLE: state_nx = rise[CTRL_ARM] ? ST_ARMED : ST_IDLE;
                ST_ARMED: begin
                    if (trig_in || rise[CTRL_FORCE]) begin
                        state_nx = ST_CAPTURE;
                        idx_nx   = '0;
                        accept   = 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (data_vld) begin
                        wr       = 1'b1;
                        complete = idx == LAST;
                        idx_nx   = complete ? '0 : idx + 1'b1;
                        state_nx = complete ? ST_DONE : ST_CAPTURE;
                    end
                end
                default: begin
                    if (rise[CTRL_ARM])
                        state_nx = ST_ARMED;
                    else if (trig_in || rise[CTRL_FORCE])
                        missed_nx = 1'b1;
                end
            endcase
        end
        cap_cnt_nx = cap_cnt + CNT_W'(complete);
    end

    // shadow buffer with the current sample merged in, so the copy can include the final word
    always_comb begin
        shadow_nx = shadow;
        for (int k = 0; k < NUM_WORDS; k++)
            if (wr && idx == IDX_W'(k))
                shadow_nx[k*DATA_W +: DATA_W] = data_in;
    end

    // sequencer state, capture index, sticky missed flag and completion counter
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            missed  <= 1'b0;
            cap_cnt <= '0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            missed  <= missed_nx;
            cap_cnt <= cap_cnt_nx;
        end
    end

    // shadow capture: timestamp on trigger acceptance, words as they arrive
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            shadow_ts <= '0;
            shadow    <= '0;
        end else begin
            shadow <= shadow_nx;
            if (accept)
                shadow_ts <= ts_in;
        end
    end

    // single-cycle copy of the whole shadow to the software-visible snapshot
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            snap_ts   <= '0;
            snap_data <= '0;
        end else if (complete) begin
            snap_ts   <= shadow_ts;
            snap_data <= shadow_nx;
        end
    end

    // status is built from next-state values so it lines up with the state register
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n)
            status_out <= '0;
        else
            status_out <= pack_status(state_nx, missed_nx, cap_cnt_nx);
    end

endmodule

// File: tb/tb_adc_snap_ctrl.sv
// tb_adc_snap_ctrl: table-driven status checks plus a snapshot scoreboard for adc_snap_ctrl
module tb_adc_snap_ctrl;

    logic         user_clk   = 1'b0;
    logic         user_rst_n = 1'b0;
    logic [31:0]  ctrl_in    = '0;
    logic         trig_in    = 1'b0;
    logic [31:0]  ts_in      = '0;
    logic [31:0]  data_in    = '0;
    logic         data_vld   = 1'b0;
    logic [31:0]  snap_ts;
    logic [127:0] snap_data;
    logic [31:0]  status_out;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0]  ts;
        logic [127:0] data;
    } snap_t;
    snap_t sbq[$];

    typedef struct {
        logic [2:0]  ctrl;
        logic        trig;
        logic [31:0] ts;
        logic        vld;
        logic [31:0] data;
        logic [31:0] exp_status;
    } vec_t;
    vec_t tbl[18];

    adc_snap_ctrl dut (
        .user_clk   (user_clk),
        .user_rst_n (user_rst_n),
        .ctrl_in    (ctrl_in),
        .trig_in    (trig_in),
        .ts_in      (ts_in),
        .data_in    (data_in),
        .data_vld   (data_vld),
        .snap_ts    (snap_ts),
        .snap_data  (snap_data),
        .status_out (status_out)
    );

    always #5 user_clk = ~user_clk;

    task automatic step();
        @(posedge user_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic words(input logic [127:0] w);
        for (int k = 0; k < 4; k++) begin
            data_vld = 1'b1;
            data_in  = w[k*32 +: 32];
            step();
        end
        data_vld = 1'b0;
    endtask

    task automatic capture(input logic [31:0] ts, input logic [127:0] w, input logic [31:0] exp_final);
        sbq.push_back('{ts, w});
        ctrl_in = 32'h1; step();
        ctrl_in = 32'h0; step();
        ts_in = ts; trig_in = 1'b1; step();
        trig_in = 1'b0;
        words(w);
        chk("cap_status", status_out, exp_final);
    endtask

    // scoreboard: pop on each completion, otherwise the snapshot must not move
    logic         prev_done = 1'b0;
    logic [31:0]  prev_ts   = '0;
    logic [127:0] prev_data = '0;
    snap_t        e;
    always @(negedge user_clk) begin
        if (user_rst_n) begin
            if (status_out[2] && !prev_done) begin
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: completion with empty queue, snap_ts %0h", snap_ts);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_ts", snap_ts, e.ts);
                    chk("sb_data", snap_data, e.data);
                end
            end else begin
                chk("hold_ts", snap_ts, prev_ts);
                chk("hold_data", snap_data, prev_data);
            end
        end
        prev_done = status_out[2];
        prev_ts   = snap_ts;
        prev_data = snap_data;
    end

    initial begin
        tbl[0]  = '{3'b001, 1'b0, 32'h0,   1'b0, 32'h0,  32'h0000_0000};
        tbl[1]  = '{3'b000, 1'b0, 32'h0,   1'b0, 32'h0,  32'h0000_0001};
        tbl[2]  = '{3'b000, 1'b1, 32'h100, 1'b0, 32'h0,  32'h0000_0002};
        tbl[3]  = '{3'b000, 1'b0, 32'h101, 1'b1, 32'hA0, 32'h0000_0002};
        tbl[4]  = '{3'b000, 1'b0, 32'h102, 1'b1, 32'hA1, 32'h0000_0002};
        tbl[5]  = '{3'b000, 1'b0, 32'h103, 1'b1, 32'hA2, 32'h0000_0002};
        tbl[6]  = '{3'b000, 1'b0, 32'h104, 1'b1, 32'hA3, 32'h0000_0104};
        tbl[7]  = '{3'b001, 1'b0, 32'h105, 1'b0, 32'h0,  32'h0000_0104};
        tbl[8]  = '{3'b000, 1'b0, 32'h106, 1'b0, 32'h0,  32'h0000_0101};
        tbl[9]  = '{3'b000, 1'b1, 32'h200, 1'b0, 32'h0,  32'h0000_0102};
        tbl[10] = '{3'b000, 1'b0, 32'h201, 1'b1, 32'hB0, 32'h0000_0102};
        tbl[11] = '{3'b000, 1'b0, 32'h202, 1'b0, 32'hEE, 32'h0000_0102};
        tbl[12] = '{3'b000, 1'b0, 32'h203, 1'b0, 32'hEE, 32'h0000_0102};
        tbl[13] = '{3'b000, 1'b0, 32'h204, 1'b1, 32'hB1, 32'h0000_0102};
        tbl[14] = '{3'b000, 1'b0, 32'h205, 1'b1, 32'hB2, 32'h0000_0102};
        tbl[15] = '{3'b000, 1'b0, 32'h206, 1'b0, 32'hEE, 32'h0000_0102};
        tbl[16] = '{3'b000, 1'b0, 32'h207, 1'b1, 32'hB3, 32'h0000_0204};
        tbl[17] = '{3'b000, 1'b0, 32'h208, 1'b1, 32'hFF, 32'h0000_0204};

        step(); step();
        chk("rst_ts", snap_ts, 0);
        chk("rst_data", snap_data, 0);
        chk("rst_status", status_out, 0);
        user_rst_n = 1'b1;
        step();
        chk("idle_status", status_out, 0);

        sbq.push_back('{32'h100, {32'hA3, 32'hA2, 32'hA1, 32'hA0}});
        sbq.push_back('{32'h200, {32'hB3, 32'hB2, 32'hB1, 32'hB0}});
        for (int i = 0; i < 18; i++) begin
            ctrl_in  = {29'b0, tbl[i].ctrl};
            trig_in  = tbl[i].trig;
            ts_in    = tbl[i].ts;
            data_vld = tbl[i].vld;
            data_in  = tbl[i].data;
            step();
            chk($sformatf("vec%0d_status", i), status_out, tbl[i].exp_status);
        end
        data_vld = 1'b0;

        trig_in = 1'b1; step();
        chk("missed_set", status_out, 32'h0000_020C);
        trig_in = 1'b0; step();
        chk("missed_sticky", status_out, 32'h0000_020C);
        sbq.push_back('{32'h300, {32'hC3, 32'hC2, 32'hC1, 32'hC0}});
        ctrl_in = 32'h1; step();
        ctrl_in = 32'h0; step();
        chk("rearm_status", status_out, 32'h0000_0209);
        ts_in = 32'h300; ctrl_in = 32'h4; step();
        ctrl_in = 32'h0; step();
        chk("force_trig", status_out, 32'h0000_020A);
        words({32'hC3, 32'hC2, 32'hC1, 32'hC0});
        chk("done_missed", status_out, 32'h0000_030C);
        ctrl_in = 32'h2; step();
        ctrl_in = 32'h0; step();
        chk("clear_done", status_out, 32'h0000_0300);

        ctrl_in = 32'h1; step();
        ctrl_in = 32'h0; step();
        chk("arm4", status_out, 32'h0000_0301);
        ts_in = 32'h400; trig_in = 1'b1; step();
        trig_in = 1'b0;
        chk("trig4", status_out, 32'h0000_0302);
        data_vld = 1'b1; data_in = 32'hD0; step();
        data_in = 32'hD1; step();
        ctrl_in = 32'h2; data_in = 32'hD2; step();
        chk("clr_pending", status_out, 32'h0000_0302);
        ctrl_in = 32'h0; data_in = 32'hD3; step();
        data_vld = 1'b0;
        chk("abort_status", status_out, 32'h0000_0300);
        chk("abort_ts", snap_ts, 32'h300);
        chk("abort_data", snap_data, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
        step();
        chk("abort_cnt", status_out, 32'h0000_0300);

        ctrl_in = 32'h3; step();
        ctrl_in = 32'h0; step();
        chk("arm_clr_same", status_out, 32'h0000_0300);
        step();
        chk("arm_clr_idle", status_out, 32'h0000_0300);
        sbq.push_back('{32'h500, {32'hE3, 32'hE2, 32'hE1, 32'hE0}});
        ts_in = 32'h500; trig_in = 1'b1; ctrl_in = 32'h1; step();
        ctrl_in = 32'h0; step();
        chk("arm_trig_high", status_out, 32'h0000_0301);
        step();
        trig_in = 1'b0;
        chk("arm_trig_cap", status_out, 32'h0000_0302);
        words({32'hE3, 32'hE2, 32'hE1, 32'hE0});
        chk("done5", status_out, 32'h0000_0404);

        for (int i = 0; i < 252; i++) begin
            logic [127:0] w;
            logic [7:0]   c;
            w = {$urandom(), $urandom(), $urandom(), $urandom()};
            c = 8'(5 + i);
            capture($urandom(), w, {16'h0, c, 8'h04});
        end
        chk("cnt_wrap", status_out, 32'h0000_0004);

        ctrl_in = 32'h1; step();
        ctrl_in = 32'h0; step();
        ts_in = 32'h600; trig_in = 1'b1; step();
        trig_in = 1'b0;
        data_vld = 1'b1; data_in = 32'hF0; step();
        data_in = 32'hF1; step();
        data_vld = 1'b0;
        #2 user_rst_n = 1'b0;
        #1;
        chk("async_rst_ts", snap_ts, 0);
        chk("async_rst_data", snap_data, 0);
        chk("async_rst_status", status_out, 0);
        step(); step();
        user_rst_n = 1'b1;
        step();
        chk("post_rst_status", status_out, 0);
        chk("post_rst_ts", snap_ts, 0);

        chk("sb_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
